fc_mac_rr_scheduler: RTL

- Shares one saturating MAC unit (a/b operands, valid_in, clear, accumulated f) among NUM_REQ dot-product requesters, such as several FC layer controllers or neuron lanes.
- Grants the MAC for one whole burst, meaning the operand pairs up to and including the beat flagged last, then drains the MAC pipeline.
- Returns the accumulated result tagged with the requester id on a valid/ready port, with round-robin fairness between bursts.

---
 rtl/fc_sched_pkg.sv | 16 +
 rtl/fc_mac_rr_scheduler_arbiter.sv | 34 +++
 rtl/fc_mac_rr_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fc_sched_pkg.sv
// Shared types and default sizing for the FC-layer MAC round-robin scheduler.
package fc_sched_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 16;
    localparam int MAC_LAT_DEF = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        BURST = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } sched_state_t;

endpackage

// File: rtl/fc_mac_rr_scheduler_arbiter.sv
// Combinational round-robin pick: first asserted request at or above the
// pointer, wrapping around. Produces a one-hot grant and its encoded id.
module fc_sched_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDW-1:0]     gnt_id,
    output logic               any_gnt
);

    logic [IDW-1:0] idx_s;

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any_gnt    = 1'b0;
        idx_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!any_gnt && req[idx_s]) begin
                any_gnt           = 1'b1;
                gnt_id            = idx_s;
                gnt_onehot[idx_s] = 1'b1;
            end else begin
                any_gnt = any_gnt;
            end
        end
    end

endmodule

// File: rtl/fc_mac_rr_scheduler.sv
// Shares one saturating MAC among NUM_REQ dot-product requesters. A requester
// owns the MAC for a whole burst (through its last beat), the pipeline is then
// drained and the accumulated value is returned tagged with the requester id.
// Build option: define FC_SCHED_RELU_EN to clamp negative results to zero.
module fc_mac_rr_scheduler
    import fc_sched_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int WIDTH   = WIDTH_DEF,
    parameter  int MAC_LAT = MAC_LAT_DEF,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [WIDTH-1:0]         mac_a,
    output logic [WIDTH-1:0]         mac_b,
    output logic                     mac_valid_in,
    output logic                     mac_clear,
    input  logic [WIDTH-1:0]         mac_f,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [IDW-1:0]           res_id,
    output logic                     busy
);

    localparam int CNT_W = $clog2(MAC_LAT + 2);

    sched_state_t       state_r;
    sched_state_t       state_n;
    logic [IDW-1:0]     gnt_r;
    logic [IDW-1:0]     rr_ptr_r;
    logic [IDW-1:0]     next_ptr_s;
    logic [IDW-1:0]     arb_id_s;
    logic [NUM_REQ-1:0] gnt_oh_r;
    logic [NUM_REQ-1:0] arb_oh_s;
    logic               arb_any_s;
    logic               accept_s;
    logic               last_s;
    logic [CNT_W-1:0]   drain_cnt_r;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic [WIDTH-1:0]   capture_s;

    fc_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr_r),
        .gnt_onehot (arb_oh_s),
        .gnt_id     (arb_id_s),
        .any_gnt    (arb_any_s)
    );

    assign sel_a_s = req_a[gnt_r*WIDTH +: WIDTH];
    assign sel_b_s = req_b[gnt_r*WIDTH +: WIDTH];
    assign last_s  = |(req_last & gnt_oh_r);
    assign busy    = (state_r != IDLE);

`ifdef FC_SCHED_RELU_EN
    assign capture_s = mac_f[WIDTH-1] ? '0 : mac_f;
`else
    assign capture_s = mac_f;
`endif

    // Pointer advances past the requester just served, wrapping at NUM_REQ.
    always_comb begin
        next_ptr_s = '0;
        if (gnt_r == IDW'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = gnt_r + IDW'(1);
        end
    end

    // Next-state logic plus the grant-only ready/accept decode.
    always_comb begin
        state_n   = state_r;
        accept_s  = 1'b0;
        req_ready = '0;
        case (state_r)
            IDLE: begin
                if (arb_any_s) begin
                    state_n = CLEAR;
                end else begin
                    state_n = IDLE;
                end
            end
            CLEAR: state_n = BURST;
            BURST: begin
                req_ready = gnt_oh_r;
                accept_s  = |(req_valid & gnt_oh_r);
                if (accept_s && last_s) begin
                    state_n = DRAIN;
                end else begin
                    state_n = BURST;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == '0) begin
                    state_n = OUT;
                end else begin
                    state_n = DRAIN;
                end
            end
            OUT: begin
                if (res_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = OUT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Grant, MAC drive, drain timing and result capture/handshake registers.
    // The drain counter runs one cycle beyond MAC_LAT so the capture samples
    // mac_f with a full cycle of margin after the last beat's update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_r        <= '0;
            gnt_oh_r     <= '0;
            rr_ptr_r     <= '0;
            drain_cnt_r  <= '0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_valid_in <= 1'b0;
            mac_clear    <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_id       <= '0;
        end else begin
            mac_clear    <= 1'b0;
            mac_valid_in <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (arb_any_s) begin
                        gnt_r     <= arb_id_s;
                        gnt_oh_r  <= arb_oh_s;
                        mac_clear <= 1'b1;
                    end
                end
                BURST: begin
                    if (accept_s) begin
                        mac_a        <= sel_a_s;
                        mac_b        <= sel_b_s;
                        mac_valid_in <= 1'b1;
                        if (last_s) begin
                            drain_cnt_r <= CNT_W'(MAC_LAT + 1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == '0) begin
                        res_data  <= capture_s;
                        res_id    <= gnt_r;
                        res_valid <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - CNT_W'(1);
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        rr_ptr_r  <= next_ptr_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
